// File: rtl/riscv_apu_resp_pkg.sv
// Shared types and constants for the APU response block: opcodes, FSM states,
// latency classes and the latency-class to cycle-count mapping.
package riscv_apu_resp_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAC = 2'd3
  } apu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } apu_state_e;

  localparam logic [1:0] LAT_CLASS_0 = 2'd0;
  localparam logic [1:0] LAT_CLASS_1 = 2'd1;
  localparam logic [1:0] LAT_CLASS_2 = 2'd2;
  localparam logic [1:0] LAT_CLASS_3 = 2'd3;

  localparam int MULTI_CYCLES_DEFAULT = 4;

  // Classes 0 and 1 both finish in a single cycle.
  function automatic int lat_cycles(input logic [1:0] lat, input int multi);
    case (lat)
      LAT_CLASS_3: return multi;
      LAT_CLASS_2: return 2;
      default:     return 1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_apu_resp_if.sv
// Request/response bus between a core (master) and the APU response block (slave).
interface riscv_apu_resp_if #(
  parameter int WIDTH = 32
);
  logic                        apu_slave_req_i;
  logic                        apu_slave_gnt_o;
  logic [1:0]                  apu_slave_op_i;
  logic [1:0]                  apu_slave_lat_i;
  logic [5:0]                  apu_slave_tag_i;
  logic [2:0][WIDTH-1:0]       apu_slave_operands_i;
  logic                        apu_slave_valid_o;
  logic                        apu_slave_ready_i;
  logic [WIDTH-1:0]            apu_slave_result_o;
  logic [1:0]                  apu_slave_flags_o;
  logic [5:0]                  apu_slave_tag_o;

  modport slave (
    input  apu_slave_req_i, apu_slave_op_i, apu_slave_lat_i, apu_slave_tag_i,
           apu_slave_operands_i, apu_slave_ready_i,
    output apu_slave_gnt_o, apu_slave_valid_o, apu_slave_result_o,
           apu_slave_flags_o, apu_slave_tag_o
  );

  modport master (
    output apu_slave_req_i, apu_slave_op_i, apu_slave_lat_i, apu_slave_tag_i,
           apu_slave_operands_i, apu_slave_ready_i,
    input  apu_slave_gnt_o, apu_slave_valid_o, apu_slave_result_o,
           apu_slave_flags_o, apu_slave_tag_o
  );
endinterface

// File: rtl/riscv_apu_resp_fifo.sv
// Request queue: power-of-two depth, show-ahead read, pointers wrap naturally.
module riscv_apu_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  assign rdata_o = r_mem[r_rptr];
  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + PW'(1);
      if (pop_i)  r_rptr <= r_rptr + PW'(1);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/riscv_apu_resp.sv
// APU response block: queues granted requests, executes one at a time with a
// per-class latency and returns results in grant order over a valid/ready handshake.
module riscv_apu_resp
  import riscv_apu_resp_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int MULTI_CYCLES = MULTI_CYCLES_DEFAULT,
  parameter int WIDTH        = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  riscv_apu_resp_if.slave   apu,
  output logic              busy_o
);
  localparam int ENTRY_W = 2 + 2 + 6 + 3 * WIDTH;
  localparam int CNT_W   = $clog2(MULTI_CYCLES + 1);

  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_gnt;
  logic               w_load;

  logic [1:0]         w_head_op;
  logic [1:0]         w_head_lat;
  logic [5:0]         w_head_tag;
  logic [WIDTH-1:0]   w_head_a, w_head_b, w_head_c;
  logic [CNT_W-1:0]   w_head_l;

  apu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic [WIDTH-1:0]   r_result;
  logic [1:0]         r_flags;
  logic [5:0]         r_tag_o;

  logic [1:0]         r_op;
  logic [5:0]         r_tag;
  logic [WIDTH-1:0]   r_a, r_b, r_c;

  logic [1:0]         w_op;
  logic [WIDTH-1:0]   w_a, w_b, w_c;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic [1:0]         w_flags;

  // Grant is suppressed during reset and whenever the queue is full (no bypass).
  assign w_gnt   = apu.apu_slave_req_i & ~w_full & rst_ni;
  assign w_wdata = {apu.apu_slave_op_i, apu.apu_slave_lat_i, apu.apu_slave_tag_i,
                    apu.apu_slave_operands_i};

  riscv_apu_resp_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_gnt),
    .pop_i   (w_load),
    .wdata_i (w_wdata),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_head_a   = w_head[WIDTH-1:0];
  assign w_head_b   = w_head[2*WIDTH-1:WIDTH];
  assign w_head_c   = w_head[3*WIDTH-1:2*WIDTH];
  assign w_head_tag = w_head[3*WIDTH +: 6];
  assign w_head_lat = w_head[3*WIDTH+6 +: 2];
  assign w_head_op  = w_head[3*WIDTH+8 +: 2];
  assign w_head_l   = CNT_W'(lat_cycles(w_head_lat, MULTI_CYCLES));

  assign w_load = ~w_empty & ((r_state == ST_IDLE) |
                              ((r_state == ST_RESP) & apu.apu_slave_ready_i));

  // Single-cycle ops are resolved straight from the queue head while loading.
  assign w_op = w_load ? w_head_op : r_op;
  assign w_a  = w_load ? w_head_a  : r_a;
  assign w_b  = w_load ? w_head_b  : r_b;
  assign w_c  = w_load ? w_head_c  : r_c;

  always_comb begin
    w_sum   = {1'b0, w_a} + {1'b0, w_b};
    w_diff  = {1'b0, w_a} - {1'b0, w_b};
    w_prod  = w_a * w_b;
    w_res   = '0;
    w_carry = 1'b0;
    case (w_op)
      OP_ADD: begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
      OP_SUB: begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
      OP_MUL: w_res = w_prod;
      default: w_res = w_prod + w_c;
    endcase
    w_flags = {w_carry, (w_res == '0)};
  end

  always_ff @(posedge clk_i) begin
    if (w_load) begin
      r_op  <= w_head_op;
      r_tag <= w_head_tag;
      r_a   <= w_head_a;
      r_b   <= w_head_b;
      r_c   <= w_head_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
      r_tag_o  <= '0;
    end else if (w_load) begin
      r_cnt <= w_head_l - CNT_W'(1);
      if (w_head_l == CNT_W'(1)) begin
        r_state  <= ST_RESP;
        r_valid  <= 1'b1;
        r_result <= w_res;
        r_flags  <= w_flags;
        r_tag_o  <= w_head_tag;
      end else begin
        r_state <= ST_EXEC;
        r_valid <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_EXEC: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state  <= ST_RESP;
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_flags  <= w_flags;
            r_tag_o  <= r_tag;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (apu.apu_slave_ready_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign apu.apu_slave_gnt_o    = w_gnt;
  assign apu.apu_slave_valid_o  = r_valid;
  assign apu.apu_slave_result_o = r_result;
  assign apu.apu_slave_flags_o  = r_flags;
  assign apu.apu_slave_tag_o    = r_tag_o;
  assign busy_o = ~w_empty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_riscv_apu_resp.sv
// Bench for riscv_apu_resp: vector table through a grant-order scoreboard plus
// directed sequences for back-to-back, back-pressure and mid-operation reset.
module tb_riscv_apu_resp;
  import riscv_apu_resp_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int MC    = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  always #5 clk = ~clk;

  riscv_apu_resp_if #(.WIDTH(WIDTH)) apu ();

  riscv_apu_resp #(
    .DEPTH        (DEPTH),
    .MULTI_CYCLES (MC),
    .WIDTH        (WIDTH)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .apu    (apu),
    .busy_o (busy)
  );

  typedef struct {
    logic [31:0] res;
    logic [1:0]  fl;
    logic [5:0]  tag;
    int          exp_cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  lat;
    logic [5:0]  tag;
    logic [31:0] a, b, c;
    logic [31:0] res;
    logic [1:0]  fl;
  } vec_t;

  exp_t        sb[$];
  int          hs_cyc[$];
  vec_t        vt[10];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          g1, g2, g3, g4, gd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples late in the low phase, just before the edge that completes a handshake.
  exp_t        mon_e;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res;
  logic [1:0]  prev_fl;
  logic [5:0]  prev_tag;
  always begin
    @(negedge clk);
    #3;
    if (rst_n && apu.apu_slave_valid_o) begin
      if (prev_hold) begin
        check("hold_result", apu.apu_slave_result_o, prev_res);
        check("hold_flags", apu.apu_slave_flags_o, prev_fl);
        check("hold_tag", apu.apu_slave_tag_o, prev_tag);
      end
      if (apu.apu_slave_ready_i) begin
        check("expected_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("result", apu.apu_slave_result_o, mon_e.res);
          check("flags", apu.apu_slave_flags_o, mon_e.fl);
          check("tag", apu.apu_slave_tag_o, mon_e.tag);
          if (mon_e.exp_cyc >= 0) check("latency", cyc, mon_e.exp_cyc);
        end
        hs_cyc.push_back(cyc);
        prev_hold = 1'b0;
      end else begin
        prev_hold = 1'b1;
        prev_res  = apu.apu_slave_result_o;
        prev_fl   = apu.apu_slave_flags_o;
        prev_tag  = apu.apu_slave_tag_o;
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] lat, input logic [5:0] tag,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] res, input logic [1:0] fl, input bit chk_lat,
                       output int gcyc);
    exp_t e;
    int   l;
    @(negedge clk);
    #1;
    apu.apu_slave_req_i      = 1'b1;
    apu.apu_slave_op_i       = op;
    apu.apu_slave_lat_i      = lat;
    apu.apu_slave_tag_i      = tag;
    apu.apu_slave_operands_i = {c, b, a};
    gcyc = -1;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (apu.apu_slave_gnt_o) begin
        gcyc = cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (gcyc < 0) begin
      errors++;
      checks++;
      $display("FAIL grant_timeout: tag %0d never granted", tag);
    end else begin
      l = (lat == 2'd3) ? MC : (lat == 2'd2) ? 2 : 1;
      e.res = res;
      e.fl  = fl;
      e.tag = tag;
      e.exp_cyc = chk_lat ? gcyc + 1 + l : -1;
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(negedge clk);
    #1;
    apu.apu_slave_req_i = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #4;
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding, busy=%0b", sb.size(), busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{OP_ADD, 2'd0, 6'd12, 32'd5,        32'd7,        32'd0, 32'd12,       2'b00};
    vt[1] = '{OP_SUB, 2'd2, 6'd3,  32'd0,        32'd1,        32'd0, 32'hFFFFFFFF, 2'b10};
    vt[2] = '{OP_ADD, 2'd1, 6'd4,  32'hFFFFFFFF, 32'd1,        32'd0, 32'd0,        2'b11};
    vt[3] = '{OP_MUL, 2'd0, 6'd5,  32'd3,        32'd4,        32'd0, 32'd12,       2'b00};
    vt[4] = '{OP_MUL, 2'd2, 6'd6,  32'h10000,    32'h10000,    32'd0, 32'd0,        2'b01};
    vt[5] = '{OP_MAC, 2'd3, 6'd7,  32'd6,        32'd7,        32'd8, 32'd50,       2'b00};
    vt[6] = '{OP_SUB, 2'd1, 6'd8,  32'd10,       32'd10,       32'd0, 32'd0,        2'b01};
    vt[7] = '{OP_SUB, 2'd0, 6'd9,  32'd5,        32'd3,        32'd0, 32'd2,        2'b00};
    vt[8] = '{OP_ADD, 2'd2, 6'd10, 32'h80000000, 32'h80000000, 32'd0, 32'd0,        2'b11};
    vt[9] = '{OP_MAC, 2'd3, 6'd11, 32'hFFFFFFFF, 32'd2,        32'd3, 32'd1,        2'b00};

    rst_n                    = 1'b0;
    apu.apu_slave_req_i      = 1'b1;
    apu.apu_slave_op_i       = 2'd0;
    apu.apu_slave_lat_i      = 2'd0;
    apu.apu_slave_tag_i      = 6'd0;
    apu.apu_slave_operands_i = '0;
    apu.apu_slave_ready_i    = 1'b1;

    #3;
    check("rst_gnt", apu.apu_slave_gnt_o, 0);
    check("rst_valid", apu.apu_slave_valid_o, 0);
    check("rst_busy", busy, 0);
    check("rst_result", apu.apu_slave_result_o, 0);
    check("rst_flags", apu.apu_slave_flags_o, 0);
    check("rst_tag", apu.apu_slave_tag_o, 0);
    apu.apu_slave_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(vt[i].op, vt[i].lat, vt[i].tag, vt[i].a, vt[i].b, vt[i].c,
            vt[i].res, vt[i].fl, 1'b1, g1);
      drain();
    end

    // Three MACs with request held: third must wait for the first pop.
    hs_cyc.delete();
    issue(OP_MAC, 2'd3, 6'd30, 32'd2,     32'd3,     32'd1, 32'd7,        2'b00, 1'b1, g1);
    issue(OP_MAC, 2'd3, 6'd31, 32'd4,     32'd5,     32'd6, 32'd26,       2'b00, 1'b0, g2);
    issue(OP_MAC, 2'd3, 6'd32, 32'hFFFF,  32'hFFFF,  32'd0, 32'hFFFE0001, 2'b00, 1'b0, g3);
    drain();
    check("b2b_grant2", g2, g1 + 1);
    check("b2b_grant3", g3, g1 + 2);
    check("b2b_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      check("b2b_spacing1", hs_cyc[1] - hs_cyc[0], MC);
      check("b2b_spacing2", hs_cyc[2] - hs_cyc[1], MC);
    end

    // Back-pressure with a full queue, then single-cycle results stream out.
    hs_cyc.delete();
    apu.apu_slave_ready_i = 1'b0;
    issue(OP_ADD, 2'd0, 6'd20, 32'd1, 32'd1, 32'd0, 32'd2, 2'b00, 1'b0, g1);
    issue(OP_SUB, 2'd0, 6'd21, 32'd9, 32'd4, 32'd0, 32'd5, 2'b00, 1'b0, g2);
    issue(OP_MUL, 2'd1, 6'd22, 32'd3, 32'd3, 32'd0, 32'd9, 2'b00, 1'b0, g3);
    fork
      issue(OP_ADD, 2'd0, 6'd23, 32'd100, 32'd23, 32'd0, 32'd123, 2'b00, 1'b0, g4);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #3;
          check("full_gnt", apu.apu_slave_gnt_o, 0);
          check("stall_valid", apu.apu_slave_valid_o, 1);
          check("stall_tag", apu.apu_slave_tag_o, 20);
        end
        @(negedge clk);
        #1;
        apu.apu_slave_ready_i = 1'b1;
      end
    join
    drain();
    check("stall_count", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) begin
      for (int k = 0; k < 3; k++) check("no_bubble", hs_cyc[k+1] - hs_cyc[k], 1);
    end

    // Reset while executing with two entries queued.
    issue(OP_MAC, 2'd3, 6'd40, 32'd1, 32'd1, 32'd1, 32'd2, 2'b00, 1'b0, g1);
    issue(OP_MAC, 2'd3, 6'd41, 32'd2, 32'd2, 32'd2, 32'd6, 2'b00, 1'b0, g2);
    issue(OP_MAC, 2'd3, 6'd42, 32'd3, 32'd3, 32'd3, 32'd12, 2'b00, 1'b0, g3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", apu.apu_slave_valid_o, 0);
    check("midrst_gnt", apu.apu_slave_gnt_o, 0);
    @(negedge clk);
    #1;
    apu.apu_slave_req_i = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    check("postrst_valid", apu.apu_slave_valid_o, 0);
    check("postrst_busy", busy, 0);
    issue(OP_ADD, 2'd0, 6'd50, 32'd40, 32'd2, 32'd0, 32'd42, 2'b00, 1'b1, gd);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
